sqr_iter_square: RTL

- Iterative integer squarer: the inverse operation of the team's iterative square-root unit. It takes an N-bit root and produces its 2N-bit square.
- Method is odd-number accumulation: n^2 = 1+3+5+...+(2n-1). This reuses the same add-and-step-by-2 datapath style as the sqrt block.
- Sits beside the sqrt unit, which feeds root values back in to regenerate squares, e.g. for self-check and display paths.
- Start/done handshake with a control FSM and a separate register datapath.

---
 rtl/sqr_pkg.sv | 43 ++++
 rtl/sqr_datapath.sv | 90 +++++++++
 rtl/sqr_iter_square.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sqr_pkg.sv
// ---------------------------------------------------------------------------
// sqr_pkg
//
// Shared definitions for the iterative squarer (sqr_iter_square) and its
// datapath. The squarer is the inverse companion of the iterative sqrt unit
// and uses the same add-and-step-by-2 style of datapath.
//
// Contents:
//   state_t   - control FSM states (IDLE, ADD, DONE)
//   SQR_N     - default root width in bits
//   sqrWideW  - result/accumulator width for a given root width (2N)
//   sqrOddW   - odd-term register width for a given root width (N+1)
//
// Optional feature macro used by the files that import this package:
//   SQR_VERIFY_EN - adds a self-check of the finished square
// ---------------------------------------------------------------------------
package sqr_pkg;

  // Control states. IDLE waits for go, ADD accumulates one odd term per
  // cycle, DONE presents the finished square for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default root width; the result is twice this wide.
  localparam int SQR_N = 4;

  // Width of the running sum and of the result. The largest square,
  // (2^N-1)^2, is strictly below 2^(2N), so the sum never overflows.
  function automatic int sqrWideW(input int n);
    return 2 * n;
  endfunction

  // Width of the odd-term register. The last term added for the largest
  // root is 2*(2^N-1)-1, and the register is stepped once more after it to
  // 2*(2^N-1)+1, which still fits in N+1 bits, so it never wraps.
  function automatic int sqrOddW(input int n);
    return n + 1;
  endfunction

endpackage : sqr_pkg

// File: rtl/sqr_datapath.sv
// ---------------------------------------------------------------------------
// sqr_datapath
//
// Register datapath of the iterative squarer. Computes n^2 as the sum of
// the first n odd numbers: 1 + 3 + 5 + ... + (2n-1). The control FSM in the
// top level drives three enables; this block holds no sequencing of its own.
//
// Parameters:
//   N           root width in bits
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   i_ld        load a new job: cnt <= i_root, acc <= 0, odd <= 1
//   i_step      add one odd term: acc += odd, odd += 2, cnt -= 1
//   i_outLd     copy the running sum into the result register
//   i_root      root operand, used only on i_ld
//   o_cntZero   high when no terms remain
//   o_sqOut     last completed square, held until the next i_outLd
//   o_acc       running sum (only with SQR_VERIFY_EN, for the self-check)
//
// Optional feature macro: SQR_VERIFY_EN
// ---------------------------------------------------------------------------
module sqr_datapath
  import sqr_pkg::*;
#(
  parameter int N = SQR_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_ld,
  input  logic                 i_step,
  input  logic                 i_outLd,
  input  logic [N-1:0]         i_root,
  output logic                 o_cntZero,
  output logic [2*N-1:0]       o_sqOut
`ifdef SQR_VERIFY_EN
  ,
  output logic [2*N-1:0]       o_acc
`endif
);

  localparam int W2 = sqrWideW(N);
  localparam int W1 = sqrOddW(N);

  logic [N-1:0]  r_cnt;
  logic [W2-1:0] r_acc;
  logic [W1-1:0] r_odd;
  logic [W2-1:0] r_sqOut;
  logic [W2-1:0] w_oddWide;

  // The odd term is narrower than the sum; it is zero-extended before the
  // add so the accumulation happens at full result width.
  assign w_oddWide = W2'(r_odd);

  // The job ends once the remaining-term count reaches zero.
  assign o_cntZero = (r_cnt == '0);

  // Working registers. A load always wins over a step so a new job starts
  // from a clean state. The result register is separate so the previous
  // square stays visible while the next job is accumulating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_odd   <= W1'(1);
      r_sqOut <= '0;
    end else begin
      if (i_ld) begin
        r_cnt <= i_root;
        r_acc <= '0;
        r_odd <= W1'(1);
      end else if (i_step) begin
        r_acc <= r_acc + w_oddWide;
        r_odd <= r_odd + W1'(2);
        r_cnt <= r_cnt - N'(1);
      end
      if (i_outLd) begin
        r_sqOut <= r_acc;
      end
    end
  end

  assign o_sqOut = r_sqOut;

`ifdef SQR_VERIFY_EN
  assign o_acc = r_acc;
`endif

endmodule : sqr_datapath

// File: rtl/sqr_iter_square.sv
// ---------------------------------------------------------------------------
// sqr_iter_square
//
// Iterative integer squarer with a start/done handshake. Takes an N-bit
// root and produces its 2N-bit square by odd-number accumulation, one term
// per clock. Sits beside the iterative sqrt unit, which feeds roots back in
// to regenerate squares for self-check and display paths.
//
// Timing: a go accepted at edge k yields done in cycle k+root_in+2; a root
// of zero gives done two cycles after go with a result of zero. go is only
// looked at in IDLE; requests while busy or in DONE are dropped. With go
// held high, a new job starts in the single IDLE cycle after each DONE.
//
// Parameters:
//   N         root width in bits (result is 2N bits)
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset; aborts any job, no done pulse
//   go        start request, sampled only in IDLE
//   root_in   operand, captured on the accepted go
//   busy      high from the cycle after go is accepted through DONE
//   done      one-cycle pulse, sq_out valid in this cycle
//   sq_out    last completed square, held until the next completion
//   err       (SQR_VERIFY_EN only) result disagreed with a direct multiply
//
// Optional feature macro: SQR_VERIFY_EN
//   When defined, the accepted root is kept in a separate register and the
//   finished sum is compared against root*root during DONE. err holds the
//   outcome until the next DONE or reset. When undefined, neither the
//   capture register nor the multiplier exists.
// ---------------------------------------------------------------------------
module sqr_iter_square
  import sqr_pkg::*;
#(
  parameter int N = SQR_N
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [N-1:0]       root_in,
  output logic               busy,
  output logic               done,
  output logic [2*N-1:0]     sq_out
`ifdef SQR_VERIFY_EN
  ,
  output logic               err
`endif
);

  localparam int W2 = sqrWideW(N);

  state_t        r_state;
  logic          w_ld;
  logic          w_step;
  logic          w_outLd;
  logic          w_cntZero;
  logic [W2-1:0] w_sqOut;

`ifdef SQR_VERIFY_EN
  logic [N-1:0]  r_rootQ;
  logic          r_err;
  logic [W2-1:0] w_acc;
  logic [W2-1:0] w_refSq;
`endif

  // Datapath enables decoded from the current state. The final ADD cycle
  // (count already zero) moves the finished sum into the result register,
  // so sq_out is already valid when the FSM reaches DONE.
  assign w_ld    = (r_state == IDLE) && go;
  assign w_step  = (r_state == ADD) && !w_cntZero;
  assign w_outLd = (r_state == ADD) && w_cntZero;

  // busy and done come straight from the state register so they drop
  // together with the state on an asynchronous reset.
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  // Control FSM. DONE always returns to IDLE, which guarantees one IDLE
  // cycle between jobs even with go held high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (go) begin
            r_state <= ADD;
          end
        end
        ADD: begin
          if (w_cntZero) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  sqr_datapath #(
    .N (N)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .i_ld      (w_ld),
    .i_step    (w_step),
    .i_outLd   (w_outLd),
    .i_root    (root_in),
    .o_cntZero (w_cntZero),
    .o_sqOut   (w_sqOut)
`ifdef SQR_VERIFY_EN
    ,
    .o_acc     (w_acc)
`endif
  );

  assign sq_out = w_sqOut;

`ifdef SQR_VERIFY_EN
  // Reference square from a direct multiply of the captured root. The
  // count register is consumed during the job, so the root needs its own
  // copy to still be available in DONE.
  assign w_refSq = W2'(r_rootQ) * W2'(r_rootQ);

  // Capture the root with the job and register the comparison in DONE;
  // the flag then holds until the next DONE or a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rootQ <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_ld) begin
        r_rootQ <= root_in;
      end
      if (r_state == DONE) begin
        r_err <= (w_acc != w_refSq);
      end
    end
  end

  assign err = r_err;
`endif

endmodule : sqr_iter_square
